// File: rtl/fir_mac_sequencer.sv
// TAPS-tap FIR sequencer: for each accepted sample it walks the sliding history window,
// issuing one multiply per tap to the shared ALU and accumulating the products locally.
module fir_mac_sequencer #(
  parameter int TAPS    = 8,
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coef_wr_en,
  input  logic [$clog2(TAPS)-1:0] coef_wr_addr,
  input  logic [15:0]             coef_wr_data,
  input  logic                    in_valid,
  input  logic [15:0]             in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [ACC_W-1:0]        out_data,
  input  logic                    out_ready,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  output logic [1:0]              alu_op_sel,
  input  logic [31:0]             alu_result,
  output logic                    busy
);
  localparam int PW = $clog2(TAPS);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state;
  logic [15:0]       hist [TAPS];
  logic [15:0]       coef [TAPS];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     base;
  logic [PW-1:0]     k;
  logic [PW-1:0]     k_next;
  logic [PW-1:0]     rd_idx;
  logic [CW-1:0]     wait_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              accept;
  logic              coef_we;

  assign accept  = (state == IDLE) && in_ready && in_valid;
  // A coefficient write loses to a sample accept on the same edge.
  assign coef_we = (state == IDLE) && coef_wr_en && !accept;
  assign k_next  = k + PW'(1);
  assign rd_idx  = base - k_next;
  assign acc_sum = acc + alu_result[ACC_W-1:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (accept)
        hist[wr_ptr] <= in_data;
      if (coef_we)
        coef[coef_wr_addr] <= coef_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      base       <= '0;
      k          <= '0;
      wait_cnt   <= '0;
      acc        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op_sel <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            base       <= wr_ptr;
            wr_ptr     <= wr_ptr + PW'(1);
            acc        <= '0;
            k          <= '0;
            wait_cnt   <= '0;
            in_ready   <= 1'b0;
            // Tap 0 uses the sample being written this edge, so bypass the history array.
            alu_a      <= in_data;
            alu_b      <= coef[0];
            alu_op_sel <= 2'b01;
            state      <= MAC;
          end
        end
        MAC: begin
          if (wait_cnt == CW'(MUL_LAT - 1)) begin
            acc      <= acc_sum;
            wait_cnt <= '0;
            if (k == PW'(TAPS - 1)) begin
              out_data   <= acc_sum;
              out_valid  <= 1'b1;
              alu_a      <= '0;
              alu_b      <= '0;
              alu_op_sel <= 2'b00;
              state      <= DONE;
            end else begin
              k     <= k_next;
              alu_a <= hist[rd_idx];
              alu_b <= coef[k_next];
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Sequences the shared 16x16 ALU multiplier to compute one TAPS-tap FIR output per accepted input sample.
- Holds the sample history in a circular buffer and the coefficients in a local register file.
- For each tap it issues one multiply to the ALU (op_sel 2'b01), waits the ALU latency, and accumulates the product locally.
- Sits between the sample source/sink handshakes and the alu instance in the FIR core.

Parameters:
- TAPS, 8, number of filter taps (power of two, >=2).
- MUL_LAT, 2, rising edges from the ALU operands being presented to alu_result being valid (>=1).
- ACC_W, 32, accumulator/output width; equal to the ALU result width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  $clog2(TAPS)  coefficient index k.
- coef_wr_data  in  16  coefficient h[k], unsigned.
- in_valid  in  1  input sample valid.
- in_data  in  16  input sample x[n], unsigned.
- in_ready  out  1  sequencer can accept a sample.
- out_valid  out  1  FIR result valid.
- out_data  out  ACC_W  y[n] = sum over k of h[k]*x[n-k], modulo 2^ACC_W.
- out_ready  in  1  sink accepts the result.
- alu_a  out  16  ALU operand a (sample).
- alu_b  out  16  ALU operand b (coefficient).
- alu_op_sel  out  2  ALU operation select.
- alu_result  in  32  ALU result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, tap counter=0, write pointer=0, acc=0.
  - All TAPS sample entries and all TAPS coefficients cleared to 0.
  - Outputs: in_ready=0 while rst is asserted, then 1 from the first cycle after release. out_valid=0, out_data=0, alu_a=0, alu_b=0, alu_op_sel=2'b00, busy=0.
- States:
  - IDLE: in_ready=1. If in_valid=1 at a rising edge:
    - write in_data to buf[wr_ptr]; base <= wr_ptr; wr_ptr <= wr_ptr+1 (wraps at TAPS);
    - acc <= 0, k <= 0, wait counter <= 0; go to MAC.
  - MAC:
    - Drive alu_a = buf[(base-k) mod TAPS], alu_b = h[k], alu_op_sel = 2'b01.
    - Operands are held stable for exactly MUL_LAT cycles per tap.
    - On the MUL_LAT-th rising edge of tap k: acc <= acc + alu_result, truncated to ACC_W bits.
    - If k < TAPS-1 at that edge: k <= k+1 and the wait counter restarts.
    - If k = TAPS-1: out_data <= acc + alu_result; go to DONE.
  - DONE:
    - out_valid=1; out_data held stable; alu_op_sel=2'b00, alu_a=alu_b=0.
    - On a rising edge with out_ready=1: go to IDLE; out_valid drops in the next cycle.
- Outside MAC, alu_a=alu_b=0 and alu_op_sel=2'b00.
- Latency: a sample accepted at edge E gives out_valid=1 after edge E + TAPS*MUL_LAT. Defaults: 16 cycles.
- Throughput: at most one sample per TAPS*MUL_LAT + 2 cycles when out_ready is held high.
- in_ready=0 in MAC and DONE. in_valid is ignored there; the sample is not consumed.
- Coefficient writes:
  - Take effect on the rising edge only when state=IDLE and no sample is accepted on the same edge.
  - A write on the same edge as a sample accept is dropped.
  - Writes in MAC or DONE are ignored, so coefficients stay constant for a whole output.
- Arithmetic:
  - All operands and products are unsigned.
  - The accumulator wraps modulo 2^ACC_W with no saturation and no overflow flag.
- History: samples persist across outputs (a true sliding window). Unwritten entries read as 0 after reset.
- Reset mid-operation (in MAC or DONE): abort immediately. A pending out_valid is lost and history plus coefficients are cleared.

Test Plan:
- Impulse response: load h[k]=k+1 (k=0..7), feed samples 1,0,0,0,0,0,0,0,0 with out_ready=1 -> out_data = 1,2,3,4,5,6,7,8,0.
- Latency/handshake: accept a sample at edge E -> out_valid first high after edge E+16. in_ready=0 and busy=1 for edges E+1..E+17. alu_op_sel=2'b01 for exactly 16 cycles. Each alu_a/alu_b pair is stable for 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out_data unchanged. An in_valid pulse during this time is not accepted. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Wrap-around: all h=0xFFFF, eight samples of 0xFFFF -> eighth output = 0xFFF00008.
- Coefficient-write gating: write h[0]=5 while in MAC -> ignored, output uses the old h[0]. The same write in IDLE is applied to the next output. A write on the same edge as an accept is dropped.
- Reset mid-MAC: assert rst at tap 3 -> out_valid=0, alu_op_sel=2'b00 immediately. After release, impulse 1 with h reloaded -> out_data=h[0], with no stale history contribution.
